// File: rtl/core_pkg.sv
// Shared decode constants and types for the RV32I core pipeline stages.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } id_fsm_e;

    typedef struct packed {
        logic re1;
        logic re2;
        logic rd_we;
        logic is_load;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/core_id_stage_if.sv
// Bundles the IF, regfile, hazard and EX-side signals seen by the ID stage.
interface core_id_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic            i_valid;
    logic [XLEN-1:0] i_pc;
    logic [31:0]     i_instr;
    logic            o_ready;
    logic            o_re1;
    logic            o_re2;
    logic [4:0]      o_raddr1;
    logic [4:0]      o_raddr2;
    logic            o_rd_latch;
    logic            i_flush;
    logic            i_ld_pend;
    logic [4:0]      i_ld_rd;
    logic            o_valid;
    logic            i_ex_ready;
    logic [XLEN-1:0] o_pc;
    logic [31:0]     o_instr;
    logic            o_rd_we;
    logic [4:0]      o_rd;
    logic            o_is_load;
    logic            o_illegal;
    logic [CNT_W-1:0] o_stall_cnt;

    modport slave (
        input  i_valid, i_pc, i_instr, i_flush, i_ld_pend, i_ld_rd, i_ex_ready,
        output o_ready, o_re1, o_re2, o_raddr1, o_raddr2, o_rd_latch,
               o_valid, o_pc, o_instr, o_rd_we, o_rd, o_is_load, o_illegal, o_stall_cnt
    );

    modport master (
        output i_valid, i_pc, i_instr, i_flush, i_ld_pend, i_ld_rd, i_ex_ready,
        input  o_ready, o_re1, o_re2, o_raddr1, o_raddr2, o_rd_latch,
               o_valid, o_pc, o_instr, o_rd_we, o_rd, o_is_load, o_illegal, o_stall_cnt
    );

endinterface

// File: rtl/core_id_decode.sv
// Combinational opcode classifier: register-port usage, writeback, load and illegal flags.
module core_id_decode
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    output dec_t       dec
);

    logic rd_nz;
    assign rd_nz = (rd != 5'd0);

    always_comb begin
        dec = '0;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                dec.rd_we = rd_nz;
            end
            OPC_JALR, OPC_OP_IMM: begin
                dec.re1   = 1'b1;
                dec.rd_we = rd_nz;
            end
            OPC_LOAD: begin
                dec.re1     = 1'b1;
                dec.rd_we   = rd_nz;
                dec.is_load = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                dec.re1 = 1'b1;
                dec.re2 = 1'b1;
            end
            OPC_OP: begin
                dec.re1   = 1'b1;
                dec.re2   = 1'b1;
                dec.rd_we = rd_nz;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/core_id_stage.sv
// RV32I instruction-decode stage: regfile read issue, load-use hazard detection,
// single-entry ID pipeline register towards EX and a hazard-stall counter.
module core_id_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    core_id_stage_if.slave  bus
);

    dec_t             dec;
    id_fsm_e          state, state_nxt;
    logic             re1, re2;
    logic [4:0]       rs1, rs2;
    logic             hazard, ready, accept, drain;
    logic [XLEN-1:0]  pc_q;
    logic [31:0]      instr_q;
    logic             rd_we_q, is_load_q, illegal_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;

    core_id_decode u_decode (
        .opcode (bus.i_instr[6:0]),
        .rd     (bus.i_instr[11:7]),
        .dec    (dec)
    );

    assign rs1 = bus.i_instr[19:15];
    assign rs2 = bus.i_instr[24:20];
    assign re1 = bus.i_valid & dec.re1;
    assign re2 = bus.i_valid & dec.re2;

    // A source matches either a load still in EX or a load sitting in our own register.
    always_comb begin
        hazard = 1'b0;
        if (re1 && rs1 != 5'd0 &&
            ((bus.i_ld_pend && bus.i_ld_rd == rs1) ||
             (state == FULL && is_load_q && rd_q == rs1)))
            hazard = 1'b1;
        if (re2 && rs2 != 5'd0 &&
            ((bus.i_ld_pend && bus.i_ld_rd == rs2) ||
             (state == FULL && is_load_q && rd_q == rs2)))
            hazard = 1'b1;
    end

    assign drain  = (state == FULL) & bus.i_ex_ready;
    assign ready  = ~bus.i_flush & ~hazard & ((state == EMPTY) | bus.i_ex_ready);
    assign accept = bus.i_valid & ready;

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = FULL;
        else if (drain || bus.i_flush)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            instr_q   <= NOP_INSTR;
            rd_we_q   <= 1'b0;
            rd_q      <= 5'd0;
            is_load_q <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            pc_q      <= bus.i_pc;
            instr_q   <= bus.i_instr;
            rd_we_q   <= dec.rd_we;
            rd_q      <= bus.i_instr[11:7];
            is_load_q <= dec.is_load;
            illegal_q <= dec.illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (bus.i_valid && hazard && !bus.i_flush)
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.o_ready     = ready;
    assign bus.o_re1       = re1;
    assign bus.o_re2       = re2;
    assign bus.o_raddr1    = rs1;
    assign bus.o_raddr2    = rs2;
    assign bus.o_rd_latch  = (state == FULL) & ~bus.i_ex_ready & ~bus.i_flush;
    assign bus.o_valid     = (state == FULL);
    assign bus.o_pc        = pc_q;
    assign bus.o_instr     = instr_q;
    assign bus.o_rd_we     = rd_we_q;
    assign bus.o_rd        = rd_q;
    assign bus.o_is_load   = is_load_q;
    assign bus.o_illegal   = illegal_q;
    assign bus.o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_core_id_stage.sv
// Self-checking bench for core_id_stage: reference model plus scoreboard of instructions bound for EX.
module tb_core_id_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    core_id_stage_if #(.XLEN(32), .CNT_W(32)) bus ();

    core_id_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_we;
        logic [4:0]  rd;
        logic        is_load;
        logic        illegal;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;

    // Returns {re1, re2, rd_we, is_load, illegal} for an instruction word.
    function automatic logic [4:0] ref_decode(input logic [31:0] instr);
        logic [4:0] r;
        logic       wr;
        wr = (instr[11:7] != 5'd0);
        case (instr[6:0])
            7'h37, 7'h17, 7'h6F: r = {2'b00, wr, 2'b00};
            7'h67, 7'h13:        r = {2'b10, wr, 2'b00};
            7'h03:               r = {2'b10, wr, 2'b10};
            7'h63, 7'h23:        r = 5'b11000;
            7'h33:               r = {2'b11, wr, 2'b00};
            default:             r = 5'b00001;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkRegs();
        checkOutput("o_valid", 32'(bus.o_valid), 32'(sbq.size() != 0));
        if (sbq.size() != 0) begin
            checkOutput("o_pc",      bus.o_pc,              sbq[0].pc);
            checkOutput("o_instr",   bus.o_instr,           sbq[0].instr);
            checkOutput("o_rd_we",   32'(bus.o_rd_we),      32'(sbq[0].rd_we));
            checkOutput("o_rd",      32'(bus.o_rd),         32'(sbq[0].rd));
            checkOutput("o_is_load", 32'(bus.o_is_load),    32'(sbq[0].is_load));
            checkOutput("o_illegal", 32'(bus.o_illegal),    32'(sbq[0].illegal));
        end
        checkOutput("o_stall_cnt", bus.o_stall_cnt, model_cnt);
    endtask

    // One clock cycle: drive at posedge+1, check comb outputs mid-cycle, advance model, check registers.
    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic flush, input logic ld_pend, input logic [4:0] ld_rd,
                                 input logic ex_ready);
        logic [4:0] d;
        logic       re1, re2, hz, mvalid, rdy, latch;
        logic [4:0] rs1, rs2;
        exp_t       e;
        bus.i_valid    = valid;
        bus.i_pc       = pc;
        bus.i_instr    = instr;
        bus.i_flush    = flush;
        bus.i_ld_pend  = ld_pend;
        bus.i_ld_rd    = ld_rd;
        bus.i_ex_ready = ex_ready;
        #3;
        d      = ref_decode(instr);
        re1    = valid & d[4];
        re2    = valid & d[3];
        rs1    = instr[19:15];
        rs2    = instr[24:20];
        mvalid = (sbq.size() != 0);
        hz     = 1'b0;
        if (re1 && rs1 != 5'd0 && ((ld_pend && ld_rd == rs1) ||
            (mvalid && sbq[0].is_load && sbq[0].rd == rs1)))
            hz = 1'b1;
        if (re2 && rs2 != 5'd0 && ((ld_pend && ld_rd == rs2) ||
            (mvalid && sbq[0].is_load && sbq[0].rd == rs2)))
            hz = 1'b1;
        rdy   = !flush && !hz && (!mvalid || ex_ready);
        latch = mvalid && !ex_ready && !flush;
        checkOutput("o_ready",    32'(bus.o_ready),    32'(rdy));
        checkOutput("o_re1",      32'(bus.o_re1),      32'(re1));
        checkOutput("o_re2",      32'(bus.o_re2),      32'(re2));
        checkOutput("o_raddr1",   32'(bus.o_raddr1),   32'(rs1));
        checkOutput("o_raddr2",   32'(bus.o_raddr2),   32'(rs2));
        checkOutput("o_rd_latch", 32'(bus.o_rd_latch), 32'(latch));
        @(posedge clk);
        if (valid && hz && !flush)
            model_cnt = model_cnt + 32'd1;
        if (valid && rdy) begin
            if (mvalid)
                e = sbq.pop_front();
            e.pc      = pc;
            e.instr   = instr;
            e.rd_we   = d[2];
            e.rd      = instr[11:7];
            e.is_load = d[1];
            e.illegal = d[0];
            sbq.push_back(e);
        end else if (mvalid && (ex_ready || flush)) begin
            e = sbq.pop_front();
        end
        #1;
        checkRegs();
    endtask

    task automatic idle(input logic ex_ready);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, ex_ready);
    endtask

    initial begin
        logic [6:0]  opcs [6];
        logic [31:0] rinstr;
        bus.i_valid    = 1'b0;
        bus.i_pc       = '0;
        bus.i_instr    = '0;
        bus.i_flush    = 1'b0;
        bus.i_ld_pend  = 1'b0;
        bus.i_ld_rd    = '0;
        bus.i_ex_ready = 1'b0;
        opcs = '{7'h03, 7'h33, 7'h13, 7'h23, 7'h63, 7'h37};

        #12;
        checkOutput("reset_valid", 32'(bus.o_valid),   32'd0);
        checkOutput("reset_pc",    bus.o_pc,           32'd0);
        checkOutput("reset_instr", bus.o_instr,        32'h0000_0013);
        checkOutput("reset_rd_we", 32'(bus.o_rd_we),   32'd0);
        checkOutput("reset_cnt",   bus.o_stall_cnt,    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADDI x1,x0,5 then ADD x2,x1,x1 back to back
        applyStimulus(1'b1, 32'h00, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b1, 32'h04, 32'h0010_8133, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("stream_rd",    32'(bus.o_rd),    32'd2);
        checkOutput("stream_rd_we", 32'(bus.o_rd_we), 32'd1);
        checkOutput("stream_cnt",   bus.o_stall_cnt,  32'd0);
        idle(1'b1);

        // LW x5,0(x1) then ADD x6,x5,x0: bubble, then EX-side load pending for two more cycles
        applyStimulus(1'b1, 32'h08, 32'h0000_A283, 1'b0, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b1, 32'h0C, 32'h0002_8333, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("lu_bubble", 32'(bus.o_valid), 32'd0);
        checkOutput("lu_cnt1",   bus.o_stall_cnt,  32'd1);
        applyStimulus(1'b1, 32'h0C, 32'h0002_8333, 1'b0, 1'b1, 5'd5, 1'b1);
        applyStimulus(1'b1, 32'h0C, 32'h0002_8333, 1'b0, 1'b1, 5'd5, 1'b1);
        checkOutput("lu_cnt3",   bus.o_stall_cnt,  32'd3);
        applyStimulus(1'b1, 32'h0C, 32'h0002_8333, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("lu_accept", bus.o_pc,         32'h0C);

        // EX backpressure for three cycles, then release
        applyStimulus(1'b1, 32'h10, 32'h0070_0193, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h14, 32'h0080_0213, 1'b0, 1'b0, 5'd0, 1'b0);
            checkOutput("bp_pc_hold",    bus.o_pc,    32'h10);
            checkOutput("bp_instr_hold", bus.o_instr, 32'h0070_0193);
        end
        applyStimulus(1'b1, 32'h14, 32'h0080_0213, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("bp_release_pc", bus.o_pc, 32'h14);

        // Flush while FULL with an offer pending
        applyStimulus(1'b1, 32'h18, 32'h0090_0293, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("flush_valid", 32'(bus.o_valid), 32'd0);

        // LW x0 followed by ADD x1,x0,x0 never hazards; illegal opcode 0x7F
        applyStimulus(1'b1, 32'h1C, 32'h0000_A003, 1'b0, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b1, 32'h20, 32'h0000_00B3, 1'b0, 1'b1, 5'd0, 1'b1);
        checkOutput("x0_no_hazard_pc", bus.o_pc,        32'h20);
        checkOutput("x0_no_hazard_cnt", bus.o_stall_cnt, 32'd3);
        applyStimulus(1'b1, 32'h24, 32'h0000_01FF, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("illegal_flag",  32'(bus.o_illegal), 32'd1);
        checkOutput("illegal_rd_we", 32'(bus.o_rd_we),   32'd0);
        idle(1'b1);

        // Randomised traffic mixing loads, hazards, backpressure and flushes
        for (int i = 0; i < 80; i++) begin
            rinstr = {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b010,
                      5'($urandom_range(0, 7)), opcs[$urandom_range(0, 5)]};
            applyStimulus(1'($urandom_range(0, 3) != 0), 32'h100 + 32'(i * 4), rinstr,
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        end

        // Load something, then assert reset asynchronously mid-cycle
        applyStimulus(1'b1, 32'h200, 32'h0000_A283, 1'b0, 1'b0, 5'd0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("midrst_instr", bus.o_instr,      32'h0000_0013);
        checkOutput("midrst_cnt",   bus.o_stall_cnt,  32'd0);
        sbq.delete();
        model_cnt = '0;
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h300, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
